// File: rtl/sync_hs_src_ctrl.sv
// Source-domain side of a 4-phase req/ack transfer into another clock domain:
// local valid/ready intake, level req with held data, synchronized ack, ack watchdog.

module sync_level2level #(
  parameter int SIGNAL_WIDTH = 1,
  parameter int FLOP_NUM     = 2
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [SIGNAL_WIDTH-1:0] data_i,
  output logic [SIGNAL_WIDTH-1:0] data_o
);

  logic [SIGNAL_WIDTH-1:0] sync_q [FLOP_NUM];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < FLOP_NUM; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= data_i;
      for (int i = 1; i < FLOP_NUM; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign data_o = sync_q[FLOP_NUM-1];

endmodule

module sync_hs_src_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_FLOP   = 3,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  src_vld,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_rdy,
  output logic                  cdc_req,
  output logic [DATA_WIDTH-1:0] cdc_data,
  input  logic                  cdc_ack_async,
  output logic                  xfer_done,
  output logic                  busy,
  input  logic                  err_clr,
  output logic                  err_timeout,
  output logic [1:0]            dbg_state
);

  // Handshake: a word moves on src_vld & src_rdy at a rising clk edge;
  // src_rdy never depends on src_vld, and src_data is ignored otherwise.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_evt;
  logic                  ack_s;

  sync_level2level #(
    .SIGNAL_WIDTH (1),
    .FLOP_NUM     (SYNC_FLOP)
  ) u_ack_sync (
    .clk    (clk),
    .rst_b  (rst_b),
    .data_i (cdc_ack_async),
    .data_o (ack_s)
  );

  // A stale ack left high by the far side blocks intake until it drops.
  assign src_rdy = (state_q == IDLE) && !ack_s;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (src_vld && src_rdy) begin
          data_d  = src_data;
          req_d   = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Watchdog only reports; the handshake keeps waiting regardless.
  always_comb begin
    cnt_d       = '0;
    timeout_evt = 1'b0;
    err_d       = err_q;
    if (ACK_TIMEOUT != 0) begin
      if (state_q != IDLE && state_d == state_q) begin
        cnt_d       = (cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        timeout_evt = (cnt_q == CNT_PRE);
      end
      if (err_clr)     err_d = 1'b0;
      if (timeout_evt) err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cdc_req     = req_q;
  assign cdc_data    = data_q;
  assign xfer_done   = done_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

  a_data_hold: assert property (@(posedge clk) disable iff (!rst_b)
    (state_q == WAIT_HI && state_d == WAIT_HI) |=> $stable(data_q));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_b)
    done_q |=> !done_q);

  a_req_low_idle: assert property (@(posedge clk) disable iff (!rst_b)
    (state_q == IDLE) |-> !req_q);

endmodule
